// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer
//   Assembles a UART byte stream of R,G,B triplets into 24-bit pixels and
//   writes them row-major into the frame buffer through a valid/ready style
//   write port. Tracks the byte phase, generates linear addresses, wraps at
//   the end of the frame, drops pixels under back-pressure and resyncs after
//   a stalled partial pixel.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             pulse: restart the frame at address 0
//   rx_data_i/rx_valid_i  received byte and its one-cycle strobe
//   wr_addr_o/wr_data_o/wr_en_o  write request ({R,G,B}, R in [23:16])
//   wr_ready_i          memory accepts the write this cycle
//   frame_done_o        pulse after the last pixel of the frame is written
//   overflow_o          sticky: a pixel was dropped due to back-pressure
//   sync_err_o          pulse: partial pixel discarded by idle timeout
//   busy_o              mid-pixel or write pending
module rgb_frame_writer #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [23:0]       wr_data_o,
    output logic              wr_en_o,
    input  logic              wr_ready_i,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              sync_err_o,
    output logic              busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_e;

    phase_e            phase_q;
    logic [7:0]        r_q, g_q;
    logic [CNT_W-1:0]  idle_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       wr_data_q;
    logic              wr_en_q;
    logic              frame_done_q;
    logic              overflow_q;
    logic              sync_err_q;

    logic              xfer;
    logic [ADDR_W-1:0] addr_d;

    // addr_q is always the address of the pending (or next) pixel, so it is
    // driven straight out; it only moves when a transfer completes.
    assign xfer   = wr_en_q && wr_ready_i;
    assign addr_d = !xfer                ? addr_q :
                    (addr_q == ADDR_LAST) ? '0     : addr_q + ADDR_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q      <= PH_R;
            r_q          <= '0;
            g_q          <= '0;
            idle_q       <= '0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else if (start_i) begin
            // A coincident transfer still reaches memory, but the frame
            // restarts regardless; any coincident byte is discarded.
            phase_q      <= PH_R;
            idle_q       <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_done_q <= xfer && (addr_q == ADDR_LAST);
            sync_err_q   <= 1'b0;
            addr_q       <= addr_d;
            if (xfer)
                wr_en_q <= 1'b0;

            if (rx_valid_i) begin
                idle_q <= '0;
                case (phase_q)
                    PH_R: begin
                        r_q     <= rx_data_i;
                        phase_q <= PH_G;
                    end
                    PH_G: begin
                        g_q     <= rx_data_i;
                        phase_q <= PH_B;
                    end
                    PH_B: begin
                        phase_q <= PH_R;
                        // Slot is free if idle or draining this very edge;
                        // otherwise the new pixel is lost.
                        if (!wr_en_q || xfer) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {r_q, g_q, rx_data_i};
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    default: phase_q <= PH_R;
                endcase
            end else if (phase_q != PH_R) begin
                if (idle_q == CNT_LAST) begin
                    phase_q    <= PH_R;
                    idle_q     <= '0;
                    sync_err_q <= 1'b1;
                end else begin
                    idle_q <= idle_q + CNT_W'(1);
                end
            end
        end
    end

    assign wr_addr_o    = addr_q;
    assign wr_data_o    = wr_data_q;
    assign wr_en_o      = wr_en_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign sync_err_o   = sync_err_q;
    assign busy_o       = (phase_q != PH_R) || wr_en_q;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Bench for rgb_frame_writer with a small 4x2 frame and a 16-cycle timeout.
// Expected writes go into a queue as stimulus is issued; a monitor pops and
// compares on every cycle where the write port transfers.
module tb_rgb_frame_writer;

    localparam int H = 4, V = 2, AW = 3, TO = 16;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid, wr_ready;
    logic [7:0]    rx_data;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          wr_en, frame_done, overflow, sync_err, busy;

    rgb_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_en_o(wr_en),
        .wr_ready_i(wr_ready), .frame_done_o(frame_done),
        .overflow_o(overflow), .sync_err_o(sync_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0, fd_count = 0;
    logic [26:0] exp_q[$];   // {addr, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every transfer must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && frame_done) fd_count++;
        if (!rst && wr_en && wr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {5'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                chk("sb_addr", 32'(wr_addr), 32'(e[26:24]));
                chk("sb_data", 32'(wr_data), 32'(e[23:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [23:0] p);
        send(p[23:16]); send(p[15:8]); send(p[7:0]);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [23:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_sync_err"}, 32'(sync_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0; wr_ready = 1'b0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;

        // Basic pixel, one-cycle latency
        wr_ready = 1'b1;
        expect_wr(0, 24'hFF8001);
        send3(24'hFF8001);
        chk("p1_wr_en", 32'(wr_en), 1);
        chk("p1_addr", 32'(wr_addr), 0);
        chk("p1_data", 32'(wr_data), 32'hFF8001);
        tick();
        chk("p1_wr_en_drop", 32'(wr_en), 0);
        chk("p1_addr_next", 32'(wr_addr), 1);
        chk("p1_busy", 32'(busy), 0);

        // Stall: hold for 5 cycles, drop a pixel completing mid-stall
        wr_ready = 1'b0;
        expect_wr(1, 24'hAABBCC);
        send3(24'hAABBCC);
        send3(24'h010203);                 // completes while pending -> dropped
        chk("stall_overflow", 32'(overflow), 1);
        for (int i = 0; i < 2; i++) tick();
        chk("stall_wr_en", 32'(wr_en), 1);
        chk("stall_addr", 32'(wr_addr), 1);
        chk("stall_data", 32'(wr_data), 32'hAABBCC);
        wr_ready = 1'b1;
        tick();
        chk("stall_release", 32'(wr_en), 0);
        chk("stall_addr_after", 32'(wr_addr), 2);
        expect_wr(2, 24'h445566);
        send3(24'h445566);
        tick();
        chk("overflow_sticky", 32'(overflow), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ovf_clear", 32'(overflow), 0);
        chk("start_addr", 32'(wr_addr), 0);

        // Whole 4x2 frame, wrap, frame_done once
        fd_count = 0;
        for (int i = 0; i < 8; i++) begin
            expect_wr(AW'(i), {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)});
            send3({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)});
        end
        chk("frame_last_addr", 32'(wr_addr), 7);
        chk("frame_done_early", 32'(frame_done), 0);
        tick();
        chk("frame_done_pulse", 32'(frame_done), 1);
        chk("frame_wrap_addr", 32'(wr_addr), 0);
        tick();
        chk("frame_done_clear", 32'(frame_done), 0);
        chk("frame_done_count", 32'(fd_count), 1);

        // 9th pixel at address 0; next B arrives on the same edge as its transfer
        wr_ready = 1'b0;
        expect_wr(0, 24'hC0FFEE);
        send3(24'hC0FFEE);
        chk("p9_addr", 32'(wr_addr), 0);
        send(8'h5A); send(8'h5B);
        wr_ready = 1'b1;
        expect_wr(1, 24'h5A5B5C);
        send(8'h5C);
        chk("overlap_wr_en", 32'(wr_en), 1);
        chk("overlap_addr", 32'(wr_addr), 1);
        chk("overlap_data", 32'(wr_data), 32'h5A5B5C);
        chk("overlap_no_ovf", 32'(overflow), 0);
        tick();
        chk("overlap_addr_after", 32'(wr_addr), 2);

        // Timeout after R,G then 16 idle cycles
        send(8'hA1); send(8'hA2);
        chk("to_busy", 32'(busy), 1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", 32'(sync_err), 0);
        tick();
        chk("to_sync_err", 32'(sync_err), 1);
        chk("to_busy_clear", 32'(busy), 0);
        tick();
        chk("to_pulse_end", 32'(sync_err), 0);
        expect_wr(2, 24'h112233);
        send3(24'h112233);
        chk("to_resync_data", 32'(wr_data), 32'h112233);
        tick();

        // start coincident with a byte and a pending write
        wr_ready = 1'b0;
        send3(24'hDEAD01);                 // pending, will be abandoned
        send3(24'hDEAD02);                 // dropped -> overflow
        chk("st_pre_ovf", 32'(overflow), 1);
        start = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
        tick();
        start = 1'b0; rx_valid = 1'b0;
        chk("st_wr_en", 32'(wr_en), 0);
        chk("st_ovf", 32'(overflow), 0);
        chk("st_addr", 32'(wr_addr), 0);
        chk("st_busy", 32'(busy), 0);
        wr_ready = 1'b1;
        expect_wr(0, 24'h070809);
        send3(24'h070809);
        chk("st_next_data", 32'(wr_data), 32'h070809);
        tick();

        // rst with a pending write and phase G
        wr_ready = 1'b0;
        send3(24'hBEEF01);
        send(8'h77);
        rst = 1'b1; tick();
        chk_zero("rst_mid");
        rst = 1'b0;
        wr_ready = 1'b1;
        expect_wr(0, 24'hC1C2C3);
        send3(24'hC1C2C3);
        chk("rst_next_addr", 32'(wr_addr), 0);
        chk("rst_next_data", 32'(wr_data), 32'hC1C2C3);
        tick(); tick();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rgb_frame_writer.md
Name: rgb_frame_writer

Overview:
- Write-side counterpart of the display read path: takes a UART byte stream of 8-bit R,G,B triplets, assembles 24-bit pixels and writes them sequentially into the DDR frame buffer.
- The display side later reads those pixels back and reduces them to 4-bit-per-channel VGA output.
- Sits between the UART receiver and the memory-controller write port.
- Handles byte-phase tracking, linear address generation, write back-pressure, frame wrap and resync on stalled transfers.

Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- TIMEOUT_CYCLES, 1_000_000, idle clocks mid-pixel before the partial pixel is discarded

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: restart frame at address 0
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- wr_addr  out  ADDR_W  pixel address (linear, row-major)
- wr_data  out  24  {R,G,B}, R in [23:16]
- wr_en  out  1  write request
- wr_ready  in  1  memory accepts write this cycle
- frame_done  out  1  one-cycle pulse after last pixel of frame written
- overflow  out  1  sticky: pixel dropped due to back-pressure
- sync_err  out  1  one-cycle pulse: partial pixel discarded by timeout
- busy  out  1  high while phase != R or a write is pending

Behaviour:
- Reset: all outputs 0; phase=R; address=0; idle counter=0. Reset wins over every other input.
- Byte phase: R -> G -> B -> R, advancing on each rx_valid. Bytes are latched into the R, G and B holding registers.
- Pixel completion: the B byte accepted on edge N gives wr_en=1 with wr_data/wr_addr valid from cycle N+1 (1-cycle latency).
- Handshake:
  - Transfer occurs on an edge where wr_en && wr_ready.
  - wr_en, wr_data and wr_addr stay stable until the transfer.
  - After a transfer with no new pixel pending, wr_en=0 next cycle.
  - wr_ready is ignored while wr_en=0.
- Addressing:
  - Address increments by 1 after each transfer.
  - When the transfer at address H_RES*V_RES-1 completes: address -> 0 and frame_done=1 for exactly one cycle.
- Simultaneous B byte and transfer of the previous pixel: the new pixel is accepted, wr_en stays 1, and data/address update to the new pixel next cycle.
- B byte completes while a write is pending and is not transferring that cycle:
  - The new pixel is dropped.
  - overflow is set (sticky until rst or start).
  - Address does not advance.
  - Phase still returns to R.
- Timeout:
  - The idle counter clears on every rx_valid and counts while phase != R.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: phase -> R, partial bytes discarded, sync_err pulse, counter cleared.
  - A pending write is unaffected.
- start:
  - Next cycle: phase=R, address=0, idle counter=0, overflow=0.
  - A pending write is abandoned: wr_en=0 next cycle.
  - start and rx_valid in the same cycle: start wins, the byte is discarded.
  - start and a transfer in the same cycle: the transfer counts to the memory, but the address still goes to 0.
- busy is combinational from state: (phase != R) || wr_en.
- No saturation or rescaling: bytes are written verbatim.

Test Plan:
- Reset, then bytes 0xFF,0x80,0x01 with wr_ready=1 -> one cycle later wr_en=1, wr_addr=0, wr_data=0xFF8001; wr_en=0 the following cycle; address then 1.
- wr_ready=0 for 5 cycles after the first pixel -> wr_en/data/addr held stable for 5 cycles; transfer when wr_ready rises; a second pixel completing during the stall -> dropped, overflow=1, next accepted pixel at wr_addr=1.
- H_RES=4, V_RES=2, 8 pixels streamed -> addresses 0..7; frame_done pulses once after the 8th transfer; 9th pixel written at address 0.
- TIMEOUT_CYCLES=16, send R,G then idle 16 cycles -> sync_err pulse, busy=0; next 3 bytes 0x11,0x22,0x33 -> wr_data=0x112233.
- Mid-frame start coincident with rx_valid and pending write -> byte discarded, wr_en=0, overflow cleared, next pixel at wr_addr=0.
- rst asserted with wr_en=1 and phase=G -> all outputs 0 next cycle; subsequent triplet written at address 0.
